audio_buffer: RTL and testbench
===============================

# audio_buffer

Ping-pong byte buffer between the SD/WAV reader and the codec block. The upstream producer streams PCM bytes into one half while the codec reads the other half by address. Per-half full/empty flags hand each half back and forth between the two sides. The codec-facing ports are the direct counterpart of the codec's buffer interface: `codec_buffer_addr`/`codec_buffer_sel` in, data/filled out, empty back in.

## Interface
- `BUFFER_ADDR_BITS`, 9: address width of one half; each half holds 2^BUFFER_ADDR_BITS bytes, so 512 bytes (one SD block) by default.
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_data_i` in 8: producer byte.
- `wr_valid_i` in 1: producer byte valid.
- `wr_ready_o` out 1: current write half is not full.
- `wr_flush_i` in 1: end-of-stream pulse; closes the current partial half.
- `wr_overflow_o` out 1: sticky; a byte was offered while `wr_ready_o`=0.
- `codec_buffer_addr_i` in BUFFER_ADDR_BITS: read byte address within a half.
- `codec_buffer_sel_i` in 1: half being read.
- `codec_buffer_data_o` out 8: registered read data.
- `codec_buffer_filled_o` out 1: `full[codec_buffer_sel_i]`.
- `codec_buffer_empty_i` in 1: one-cycle pulse; codec has finished half `codec_buffer_sel_i`.

## Operation
- Storage is 2×2^N bytes, organised as `mem[{half, index}]`.
- State registers:
  - `full[1:0]`
  - `wr_sel`
  - `wr_idx` (N bits)
  - `wr_overflow`
  - `state` ∈ {FILL, PAD}
- FILL:
  - `wr_ready_o` = `!full[wr_sel]`.
  - A byte is accepted when `wr_valid_i && wr_ready_o`. It is written to `mem[{wr_sel, wr_idx}]` and `wr_idx` increments.
  - Accepting at `wr_idx` = 2^N−1 sets `full[wr_sel]`, toggles `wr_sel` and wraps `wr_idx` to 0.
  - Halves are filled strictly in order 0,1,0,1,…
- Writes to a full half never happen. `wr_valid_i` while not ready drops the byte and sets `wr_overflow` (cleared only by reset).
- `wr_flush_i`:
  - Acted on only in FILL with `wr_idx`≠0.
  - With `wr_idx`=0 it is ignored, so an empty half is never handed over.
  - Behaviour otherwise is per Configuration.
- Read side:
  - `codec_buffer_data_o` <= `mem[{codec_buffer_sel_i, codec_buffer_addr_i}]` every cycle.
  - Reads are legal on any half regardless of flags.
  - `codec_buffer_empty_i` clears `full[codec_buffer_sel_i]`. If that bit is already 0 the pulse is ignored.
- Simultaneous events:
  - Set on one half and clear on the other in the same cycle: both take effect.
  - Set and clear on the same half cannot coincide, because the writer only sets a non-full half and the clear is a no-op on a non-full half. The bench asserts this.
  - Same-address read and write in the same cycle returns the old data (read-before-write).

## Timing
- Reset values:
  - `full`=00, `wr_sel`=0, `wr_idx`=0, `state`=FILL.
  - `wr_ready_o`=1, `wr_overflow_o`=0.
  - `codec_buffer_data_o`=0x00, `codec_buffer_filled_o`=0.
  - Memory contents are not reset.
- Read latency is 1 cycle: address/sel presented at edge k give data after edge k+1.
- `codec_buffer_filled_o` is combinational from the `full` register and `codec_buffer_sel_i`. It rises the cycle after the last byte of the half is accepted.
- `codec_buffer_empty_i` at edge k: `wr_ready_o` (if `wr_sel` matches) is 1 after edge k.
- Throughput is 1 byte/cycle on the write side.
- Reset asserted mid-fill or mid-pad abandons all data and returns to the reset values at the next edge.

## Configuration
- `AUDIO_BUFFER_ZERO_PAD_EN` defined:
  - A flush enters PAD, which writes 0x00 at `wr_idx`, one byte per cycle, until the half wraps.
  - On wrap it sets full, toggles `wr_sel` and returns to FILL.
  - `wr_ready_o`=0 throughout PAD.
  - `wr_valid_i` during PAD is dropped and sets overflow.
- Not defined:
  - A flush immediately sets `full[wr_sel]`, toggles `wr_sel` and zeroes `wr_idx` in one cycle.
  - The tail bytes keep stale data.
  - The PAD state does not exist.

## Test plan
All scenarios run with `BUFFER_ADDR_BITS`=4 (16-byte halves).
- Reset, then write bytes 0x00..0x0F -> `full`=01, `wr_sel`=1; with sel=0, `codec_buffer_filled_o`=1; reading addr 5 gives 0x05 one cycle later.
- Fill both halves with 32 bytes, then offer a 33rd byte -> `wr_ready_o`=0, byte dropped, `wr_overflow_o`=1; empty pulse on sel=0 -> `wr_ready_o`=1 next cycle.
- Empty pulse on half 1 in the same cycle as the 16th byte of half 0 is accepted -> `full`=01 afterwards, with both updates applied.
- Write 3 bytes 0xAA, then flush -> with the macro: 13 cycles of PAD, bytes 3..15 read as 0x00, then full set; without the macro: full set next cycle and `wr_idx`=0.
- Flush with `wr_idx`=0 -> no state change; empty pulse on a non-full half -> no change.
- Assert `rst_n`=0 during PAD after 5 pad bytes -> next cycle all outputs are at their reset values and `state`=FILL.

Source files
------------

// File: rtl/audio_buffer.sv
// rtl/audio_buffer.sv - ping-pong byte buffer between the WAV reader and the codec
//
// Two halves of 2^BUFFER_ADDR_BITS bytes each. The producer fills the halves
// strictly in order 0,1,0,1,... while the codec reads the other half by
// address. full[h] marks a half as owned by the codec until it pulses empty.
//
// Optional feature macro: AUDIO_BUFFER_ZERO_PAD_EN
//   defined   - a flush zero-pads the rest of the half (PAD state) before handover
//   undefined - a flush hands the partial half over at once, tail bytes stale
//
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   wr_data_i, wr_valid_i   - producer byte stream
//   wr_ready_o              - current write half can take a byte
//   wr_flush_i              - end-of-stream pulse, closes a partial half
//   wr_overflow_o           - sticky: a byte was offered while not ready
//   codec_buffer_addr_i     - read byte address within a half
//   codec_buffer_sel_i      - half being read / released
//   codec_buffer_data_o     - registered read data, 1-cycle latency
//   codec_buffer_filled_o   - full flag of the selected half
//   codec_buffer_empty_i    - pulse: codec is done with the selected half
module audio_buffer #(
  parameter int BUFFER_ADDR_BITS = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  wr_data_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic                        wr_flush_i,
  output logic                        wr_overflow_o,
  input  logic [BUFFER_ADDR_BITS-1:0] codec_buffer_addr_i,
  input  logic                        codec_buffer_sel_i,
  output logic [7:0]                  codec_buffer_data_o,
  output logic                        codec_buffer_filled_o,
  input  logic                        codec_buffer_empty_i
);

  localparam int HALF_BYTES = 1 << BUFFER_ADDR_BITS;
  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_IDX = {BUFFER_ADDR_BITS{1'b1}};

  logic [7:0]                  mem [0:2*HALF_BYTES-1];
  logic [1:0]                  full;
  logic                        wr_sel;
  logic [BUFFER_ADDR_BITS-1:0] wr_idx;
  logic                        wr_overflow;

  logic                        in_fill;
  logic                        pad_wr;
  logic                        accept;
  logic                        flush_act;
  logic                        last_byte;
  logic                        hand_over;
  logic                        mem_we;
  logic [7:0]                  mem_wdata;
  logic [1:0]                  set_vec;
  logic [1:0]                  clr_vec;

`ifdef AUDIO_BUFFER_ZERO_PAD_EN
  typedef enum logic {FILL = 1'b0, PAD = 1'b1} state_t;
  state_t state;

  assign in_fill = (state == FILL);
  assign pad_wr  = (state == PAD);
`else
  assign in_fill = 1'b1;
  assign pad_wr  = 1'b0;
`endif

  assign wr_ready_o    = in_fill && !full[wr_sel];
  assign wr_overflow_o = wr_overflow;
  assign accept        = wr_valid_i && wr_ready_o;
  // An empty half is never handed over, so a flush at index 0 does nothing.
  assign flush_act     = wr_flush_i && in_fill && (wr_idx != '0);
  assign last_byte     = (accept || pad_wr) && (wr_idx == LAST_IDX);

`ifdef AUDIO_BUFFER_ZERO_PAD_EN
  assign hand_over = last_byte;
`else
  assign hand_over = last_byte || flush_act;
`endif

  assign mem_we    = rst_n && (accept || pad_wr);
  assign mem_wdata = accept ? wr_data_i : 8'h00;

  // The writer only ever sets a non-full half and the clear is gated on the
  // half being full, so a set and a clear can never target the same bit.
  assign set_vec = hand_over ? (2'b01 << wr_sel) : 2'b00;
  assign clr_vec = (codec_buffer_empty_i && full[codec_buffer_sel_i]) ?
                   (2'b01 << codec_buffer_sel_i) : 2'b00;

  assign codec_buffer_filled_o = full[codec_buffer_sel_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full        <= 2'b00;
      wr_sel      <= 1'b0;
      wr_idx      <= '0;
      wr_overflow <= 1'b0;
`ifdef AUDIO_BUFFER_ZERO_PAD_EN
      state       <= FILL;
`endif
    end else begin
      full <= (full | set_vec) & ~clr_vec;
      if (wr_valid_i && !wr_ready_o) begin
        wr_overflow <= 1'b1;
      end
      if (hand_over) begin
        wr_sel <= !wr_sel;
        wr_idx <= '0;
      end else if (accept || pad_wr) begin
        wr_idx <= wr_idx + 1'b1;
      end
`ifdef AUDIO_BUFFER_ZERO_PAD_EN
      case (state)
        FILL: if (flush_act && !last_byte) state <= PAD;
        PAD:  if (last_byte) state <= FILL;
        default: state <= FILL;
      endcase
`endif
    end
  end

  // Storage has no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{wr_sel, wr_idx}] <= mem_wdata;
    end
  end

  // Non-blocking read against the separate write process gives old data on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      codec_buffer_data_o <= 8'h00;
    end else begin
      codec_buffer_data_o <= mem[{codec_buffer_sel_i, codec_buffer_addr_i}];
    end
  end

endmodule

// File: tb/tb_audio_buffer.sv
// tb/tb_audio_buffer.sv - randomized scoreboard bench for audio_buffer (16-byte halves)
module tb_audio_buffer;

  localparam int N  = 4;
  localparam int HB = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   wr_data_i;
  logic         wr_valid_i;
  logic         wr_ready_o;
  logic         wr_flush_i;
  logic         wr_overflow_o;
  logic [N-1:0] codec_buffer_addr_i;
  logic         codec_buffer_sel_i;
  logic [7:0]   codec_buffer_data_o;
  logic         codec_buffer_filled_o;
  logic         codec_buffer_empty_i;

  always #5 clk = ~clk;

  audio_buffer #(.BUFFER_ADDR_BITS(N)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .wr_data_i             (wr_data_i),
    .wr_valid_i            (wr_valid_i),
    .wr_ready_o            (wr_ready_o),
    .wr_flush_i            (wr_flush_i),
    .wr_overflow_o         (wr_overflow_o),
    .codec_buffer_addr_i   (codec_buffer_addr_i),
    .codec_buffer_sel_i    (codec_buffer_sel_i),
    .codec_buffer_data_o   (codec_buffer_data_o),
    .codec_buffer_filled_o (codec_buffer_filled_o),
    .codec_buffer_empty_i  (codec_buffer_empty_i)
  );

  typedef struct {
    bit         chk_data;
    logic [7:0] data;
    logic       ready;
    logic       filled;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: per-half byte arrays, a fill count for the half being
  // written, and the ownership flags.
  logic [7:0] m_mem   [0:2*HB-1];
  bit         m_known [0:2*HB-1];
  bit   [1:0] m_full;
  int         m_half;
  int         m_cnt;
  bit         m_pad;
  bit         m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_full = 2'b00;
    m_half = 0;
    m_cnt  = 0;
    m_pad  = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_put(input logic [7:0] b);
    m_mem[m_half*HB + m_cnt]   = b;
    m_known[m_half*HB + m_cnt] = 1'b1;
    m_cnt++;
  endfunction

  // One clock: drive inputs, advance the model, queue the expected outputs.
  task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit fl,
                       input bit em, input bit sl, input logic [N-1:0] ad);
    exp_t e;
    int   rd;
    int   set_h;
    int   clr_h;
    bit   ready;
    bit   was_pad;
    int   cnt_before;
    rst_n                = !rst;
    wr_valid_i           = v;
    wr_data_i            = d;
    wr_flush_i           = fl;
    codec_buffer_empty_i = em;
    codec_buffer_sel_i   = sl;
    codec_buffer_addr_i  = ad;
    rd = int'(sl) * HB + int'(ad);
    if (rst) begin
      e.chk_data = 1'b1;
      e.data     = 8'h00;
      model_reset();
    end else begin
      e.chk_data = m_known[rd];
      e.data     = m_mem[rd];
      set_h      = -1;
      clr_h      = -1;
      ready      = !m_pad && !m_full[m_half];
      was_pad    = m_pad;
      cnt_before = m_cnt;
      if (v && !ready) m_ovf = 1'b1;
      if (em && m_full[sl]) clr_h = int'(sl);
      if (was_pad) model_put(8'h00);
      else if (v && ready) model_put(d);
      if (m_cnt == HB) begin
        set_h = m_half;
      end else if (!was_pad && fl && cnt_before != 0) begin
`ifdef AUDIO_BUFFER_ZERO_PAD_EN
        m_pad = 1'b1;
`else
        set_h = m_half;
`endif
      end
      if (set_h >= 0) begin
        assert (set_h != clr_h) else $error("set and clear on same half %0d", set_h);
        m_full[set_h] = 1'b1;
        m_half        = 1 - m_half;
        m_cnt         = 0;
        m_pad         = 1'b0;
      end
      if (clr_h >= 0) m_full[clr_h] = 1'b0;
    end
    e.ready  = !m_pad && !m_full[m_half];
    e.filled = m_full[sl];
    e.ovf    = m_ovf;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit sl, input logic [N-1:0] ad);
    cycle(0, 0, 8'h00, 0, 0, sl, ad);
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(0, 1, d, 0, 0, 0, '0);
  endtask

  task automatic reset_dut();
    cycle(1, 0, 8'h00, 0, 0, 0, '0);
    cycle(1, 0, 8'h00, 0, 0, 0, '0);
  endtask

  // Monitor: every edge the DUT presents a fresh set of outputs.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.chk_data) chk("rd_data", codec_buffer_data_o, mon_e.data);
      chk("wr_ready", {7'b0, wr_ready_o}, {7'b0, mon_e.ready});
      chk("filled", {7'b0, codec_buffer_filled_o}, {7'b0, mon_e.filled});
      chk("overflow", {7'b0, wr_overflow_o}, {7'b0, mon_e.ovf});
    end
  end

  initial begin
    rst_n                = 1'b0;
    wr_valid_i           = 1'b0;
    wr_data_i            = 8'h00;
    wr_flush_i           = 1'b0;
    codec_buffer_empty_i = 1'b0;
    codec_buffer_sel_i   = 1'b0;
    codec_buffer_addr_i  = '0;
    for (int i = 0; i < 2*HB; i++) m_known[i] = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state, then one full half.
    reset_dut();
    chk("reset_ready", {7'b0, wr_ready_o}, 8'h01);
    chk("reset_data", codec_buffer_data_o, 8'h00);
    for (int i = 0; i < HB; i++) wr(8'(i));
    chk("h0_filled", {7'b0, codec_buffer_filled_o}, 8'h01);
    chk("h1_ready", {7'b0, wr_ready_o}, 8'h01);
    idle(0, 4'd5);
    chk("h0_addr5", codec_buffer_data_o, 8'h05);

    // Both halves full, then an overflowing byte, then release half 0.
    for (int i = 0; i < HB; i++) wr(8'(8'h10 + i));
    wr(8'h20);
    chk("both_full_ready", {7'b0, wr_ready_o}, 8'h00);
    chk("ovf_set", {7'b0, wr_overflow_o}, 8'h01);
    cycle(0, 0, 8'h00, 0, 1, 0, '0);
    chk("ready_after_empty", {7'b0, wr_ready_o}, 8'h01);
    idle(0, 4'd0);
    chk("dropped_byte", codec_buffer_data_o, 8'h00);

    // Release half 1 on the same edge that completes half 0.
    for (int i = 0; i < HB-1; i++) wr(8'(8'h40 + i));
    cycle(0, 1, 8'h4F, 0, 1, 1, '0);
    chk("sim_h1_clear", {7'b0, codec_buffer_filled_o}, 8'h00);
    idle(0, '0);
    chk("sim_h0_set", {7'b0, codec_buffer_filled_o}, 8'h01);

    // Partial half closed by a flush.
    reset_dut();
    for (int i = 0; i < 3; i++) wr(8'hAA);
    cycle(0, 0, 8'h00, 1, 0, 0, '0);
`ifdef AUDIO_BUFFER_ZERO_PAD_EN
    chk("pad_ready", {7'b0, wr_ready_o}, 8'h00);
    chk("pad_not_full", {7'b0, codec_buffer_filled_o}, 8'h00);
    repeat (HB-4) idle(0, '0);
    chk("pad_still_busy", {7'b0, wr_ready_o}, 8'h00);
    idle(0, '0);
    chk("pad_done_full", {7'b0, codec_buffer_filled_o}, 8'h01);
    chk("pad_done_ready", {7'b0, wr_ready_o}, 8'h01);
    for (int i = 3; i < HB; i++) begin
      idle(0, 4'(i));
      chk("pad_zero", codec_buffer_data_o, 8'h00);
    end
`else
    chk("flush_full", {7'b0, codec_buffer_filled_o}, 8'h01);
    chk("flush_ready", {7'b0, wr_ready_o}, 8'h01);
    wr(8'h5C);
    idle(1, '0);
    chk("flush_idx0", codec_buffer_data_o, 8'h5C);
`endif
    idle(0, 4'd2);
    chk("flush_head", codec_buffer_data_o, 8'hAA);

    // Flush at index 0 and empty on a non-full half are ignored.
    reset_dut();
    cycle(0, 0, 8'h00, 1, 0, 0, '0);
    chk("flush0_ready", {7'b0, wr_ready_o}, 8'h01);
    chk("flush0_filled", {7'b0, codec_buffer_filled_o}, 8'h00);
    for (int i = 0; i < HB-1; i++) wr(8'(8'h60 + i));
    chk("flush0_not_yet", {7'b0, codec_buffer_filled_o}, 8'h00);
    wr(8'h6F);
    chk("flush0_full16", {7'b0, codec_buffer_filled_o}, 8'h01);
    cycle(0, 0, 8'h00, 0, 1, 1, '0);
    chk("empty_nonfull_h1", {7'b0, codec_buffer_filled_o}, 8'h00);
    idle(0, '0);
    chk("empty_nonfull_h0", {7'b0, codec_buffer_filled_o}, 8'h01);

    // Reset in the middle of a pad (or just after the flush without padding).
    for (int i = 0; i < 3; i++) wr(8'h77);
    cycle(0, 1, 8'h11, 0, 0, 0, '0);
    cycle(0, 0, 8'h00, 1, 0, 0, '0);
    repeat (5) idle(0, '0);
    cycle(1, 0, 8'h00, 0, 0, 0, '0);
    chk("rst_mid_ready", {7'b0, wr_ready_o}, 8'h01);
    chk("rst_mid_filled", {7'b0, codec_buffer_filled_o}, 8'h00);
    chk("rst_mid_ovf", {7'b0, wr_overflow_o}, 8'h00);
    chk("rst_mid_data", codec_buffer_data_o, 8'h00);

    // Randomized traffic against the model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit fl;
      v  = ($urandom % 4) != 0;
      fl = !v && (($urandom % 24) == 0);
      cycle(0, v, 8'($urandom), fl, ($urandom % 7) == 0, 1'($urandom), 4'($urandom));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
